// File: rtl/nes_cpu_bus.sv
// CPU-side bus responder for the NES core: work RAM, PPU/PRG decode, open bus and OAM DMA.
// Define OAM_DMA_EN to build the $4014 OAM DMA engine; without it locked is tied high.
module nes_cpu_bus #(
  parameter int RAM_AW = 11
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        locked,
  output logic [2:0]  ppu_reg,
  output logic        ppu_cs,
  output logic        ppu_we,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_address,
  input  logic [7:0]  prg_data
);

  logic [15:0] bus_addr;
  logic        in_ram;
  logic        in_ppu;
  logic        in_prg;
  logic        dma_write;
  logic [7:0]  dma_byte;

  logic [7:0]  ram_mem [2**RAM_AW];
  logic        ram_we;
  logic [7:0]  ram_rd_d, ram_rd_q;
  logic [7:0]  open_bus_d, open_bus_q;

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } dma_state_e;

  dma_state_e state_d, state_q;
  logic [7:0] page_d, page_q;
  logic [7:0] idx_d, idx_q;
  logic [7:0] dma_byte_d, dma_byte_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      page_q     <= 8'h00;
      idx_q      <= 8'h00;
      dma_byte_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      dma_byte_q <= dma_byte_d;
    end
  end

  // cpu_we only matters in IDLE, so a $4014 write during a copy cannot restart it.
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    idx_d      = idx_q;
    dma_byte_d = dma_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_we && (cpu_address == 16'h4014)) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        dma_byte_d = cpu_rdata;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d   = idx_q + 8'h01;
        state_d = (idx_q == 8'hFF) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign locked    = (state_q == ST_IDLE);
  assign dma_write = (state_q == ST_WRITE);
  assign dma_byte  = dma_byte_q;
  assign bus_addr  = locked ? cpu_address : {page_q, idx_q};
`else
  assign locked    = 1'b1;
  assign dma_write = 1'b0;
  assign dma_byte  = 8'h00;
  assign bus_addr  = cpu_address;
`endif

  assign in_ram      = (bus_addr[15:13] == 3'b000);
  assign in_ppu      = (bus_addr[15:13] == 3'b001);
  assign in_prg      = bus_addr[15];
  assign prg_address = bus_addr[14:0];

  // RAM writes come only from the CPU; DMA never targets RAM.
  assign ram_we = cpu_we & locked & (cpu_address[15:13] == 3'b000);

  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_mem[cpu_address[RAM_AW-1:0]] <= cpu_wdata;
    end
  end

  // Half-cycle read register so data is ready for the CPU's next posedge sample.
  assign ram_rd_d = ram_mem[bus_addr[RAM_AW-1:0]];

  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_rd_q <= 8'h00;
    end else begin
      ram_rd_q <= ram_rd_d;
    end
  end

  always_comb begin
    cpu_rdata = open_bus_q;
    if (in_ram) begin
      cpu_rdata = ram_rd_q;
    end else if (in_ppu) begin
      cpu_rdata = ppu_rdata;
    end else if (in_prg) begin
      cpu_rdata = prg_data;
    end
  end

  assign open_bus_d = cpu_rdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      open_bus_q <= 8'h00;
    end else begin
      open_bus_q <= open_bus_d;
    end
  end

  // DMA write cycle overrides the address-decoded PPU port.
  always_comb begin
    ppu_cs    = in_ppu & resetn;
    ppu_reg   = bus_addr[2:0];
    ppu_we    = in_ppu & resetn & cpu_we & locked;
    ppu_wdata = cpu_wdata;
    if (dma_write) begin
      ppu_cs    = 1'b1;
      ppu_reg   = 3'd4;
      ppu_we    = 1'b1;
      ppu_wdata = dma_byte;
    end
  end

endmodule
